// File: rtl/pingpong_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// pingpong_pkg : bank-select encoding and read FSM state encoding
// Rev 1.0
// ------------------------------------------------------------------
package pingpong_pkg;

  // Shared with the write-side select so both halves agree on polarity
  localparam logic BANK1 = 1'b1;
  localparam logic BANK2 = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pingpong_rd_ctrl_if.sv
`default_nettype none
// ------------------------------------------------------------------
// pingpong_rd_ctrl_if : bank handshake, read port and output stream
// Rev 1.0
// ------------------------------------------------------------------
interface pingpong_rd_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_done1;
  logic                  wr_done2;
  logic                  full1;
  logic                  full2;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_en1;
  logic                  rd_en2;
  logic [DATA_WIDTH-1:0] din1;
  logic [DATA_WIDTH-1:0] din2;
  logic                  sl_dout;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_vld;
  logic                  dout_rdy;
  logic                  ovf;

  modport slave (
    input  wr_done1, wr_done2, din1, din2, dout_rdy,
    output full1, full2, rd_addr, rd_en1, rd_en2, sl_dout, dout, dout_vld, ovf
  );

  modport master (
    output wr_done1, wr_done2, din1, din2, dout_rdy,
    input  full1, full2, rd_addr, rd_en1, rd_en2, sl_dout, dout, dout_vld, ovf
  );
endinterface
`default_nettype wire

// File: rtl/pp_skid_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// pp_skid_fifo : 2-entry output skid buffer, head entry drives o_data
// Rev 1.0
// ------------------------------------------------------------------
module pp_skid_fifo #(
  parameter int DATA_WIDTH = 8
) (
  input  wire                   clk,
  input  wire                   rst,
  input  wire                   i_push,
  input  wire                   i_pop,
  input  wire  [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [1:0]            o_count
);
  logic [DATA_WIDTH-1:0] r_mem [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;
  logic                  w_do_pop;
  logic                  w_do_push;

  assign w_do_pop  = i_pop && (r_count != 2'd0);
  assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule
`default_nettype wire

// File: rtl/pingpong_rd_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// pingpong_rd_ctrl : reads filled ping-pong banks in strict alternation
// Rev 1.0
// ------------------------------------------------------------------
module pingpong_rd_ctrl
  import pingpong_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input wire                clk,
  input wire                rst,
  pingpong_rd_ctrl_if.slave bus
);
  localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                r_state;
  state_t                w_next;
  logic                  r_sl;
  logic                  r_full1;
  logic                  r_full2;
  logic                  r_ovf;
  logic                  r_inflight;
  logic                  r_inflight_bank;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [1:0]            w_count;
  logic [2:0]            w_occ;
  logic                  w_vld;
  logic                  w_pop;
  logic                  w_credit;
  logic                  w_issue;
  logic                  w_release;
  logic                  w_sel_full;
  logic                  w_rel1;
  logic                  w_rel2;
  logic [DATA_WIDTH-1:0] w_push_data;
  logic [DATA_WIDTH-1:0] w_fifo_data;

  assign w_vld       = (w_count != 2'd0);
  assign w_pop       = w_vld && bus.dout_rdy;
  // Buffered plus in-flight words must stay within the two FIFO slots
  assign w_occ       = {1'b0, w_count} + {2'b00, r_inflight};
  assign w_credit    = w_occ < (3'd2 + {2'b00, w_pop});
  assign w_sel_full  = (r_sl == BANK1) ? r_full1 : r_full2;
  assign w_rel1      = w_release && (r_sl == BANK1);
  assign w_rel2      = w_release && (r_sl == BANK2);
  assign w_push_data = (r_inflight_bank == BANK1) ? bus.din1 : bus.din2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_issue   = 1'b0;
    w_release = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sel_full) w_next = READ;
      end
      READ: begin
        w_issue = w_credit;
        if (w_credit && (r_rd_addr == c_LAST_ADDR)) w_next = DRAIN;
      end
      DRAIN: begin
        // Release only once the final word has landed in the FIFO
        if (!r_inflight) begin
          w_release = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sl            <= BANK1;
      r_full1         <= 1'b0;
      r_full2         <= 1'b0;
      r_ovf           <= 1'b0;
      r_inflight      <= 1'b0;
      r_inflight_bank <= BANK1;
      r_rd_addr       <= '0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_bank <= r_sl;
      if (r_state == IDLE) begin
        r_rd_addr <= '0;
      end else if (w_issue) begin
        r_rd_addr <= (r_rd_addr == c_LAST_ADDR) ? '0 : r_rd_addr + ADDR_WIDTH'(1);
      end
      if (w_release) r_sl <= ~r_sl;
      r_full1 <= bus.wr_done1 || (r_full1 && !w_rel1);
      r_full2 <= bus.wr_done2 || (r_full2 && !w_rel2);
      if ((bus.wr_done1 && r_full1 && !w_rel1) || (bus.wr_done2 && r_full2 && !w_rel2)) begin
        r_ovf <= 1'b1;
      end
    end
  end

  pp_skid_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (r_inflight),
    .i_pop  (w_pop),
    .i_data (w_push_data),
    .o_data (w_fifo_data),
    .o_count(w_count)
  );

  assign bus.full1    = r_full1;
  assign bus.full2    = r_full2;
  assign bus.ovf      = r_ovf;
  assign bus.sl_dout  = r_sl;
  assign bus.rd_addr  = r_rd_addr;
  assign bus.rd_en1   = w_issue && (r_sl == BANK1);
  assign bus.rd_en2   = w_issue && (r_sl == BANK2);
  assign bus.dout     = w_fifo_data;
  assign bus.dout_vld = w_vld;
endmodule
`default_nettype wire

// File: doc/pingpong_rd_ctrl.md
Name: pingpong_rd_ctrl

Overview:
Read-side controller for the ping-pong buffer. It is the counterpart of the write-side input select that steers din into bunit1 or bunit2.
- Tracks which bank the writer has filled and reads that bank out sequentially through a shared read address.
- Muxes the two bank read-data buses onto one valid/ready stream.
- Releases each bank back to the writer once its last word has been captured.
- Banks are consumed in strict alternation, starting with bunit1.

Parameters:
DATA_WIDTH, 8, width of bank words and output stream
DEPTH, 16, words per bank per fill (2..2**ADDR_WIDTH)
ADDR_WIDTH, 4, bank address width

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
wr_done1  input  1  one-cycle pulse: writer finished filling bunit1
wr_done2  input  1  one-cycle pulse: writer finished filling bunit2
full1  output  1  bunit1 holds unread data; writer must not write it
full2  output  1  bunit2 holds unread data
rd_addr  output  ADDR_WIDTH  shared read address to both banks
rd_en1  output  1  read strobe, bunit1
rd_en2  output  1  read strobe, bunit2
din1  input  DATA_WIDTH  bunit1 read data, valid 1 cycle after rd_en1
din2  input  DATA_WIDTH  bunit2 read data, valid 1 cycle after rd_en2
sl_dout  output  1  bank currently being read: 1 = bunit1, 0 = bunit2
dout  output  DATA_WIDTH  output stream data
dout_vld  output  1  dout valid
dout_rdy  input  1  downstream ready
ovf  output  1  sticky: wr_done for a bank that is already full and not being released

Behaviour:
- Reset (async, active-high):
  - full1 = full2 = 0, ovf = 0, sl_dout = 1.
  - rd_addr = 0, rd_en1 = rd_en2 = 0, dout_vld = 0, dout = 0.
  - FSM = IDLE; output buffer and in-flight flag cleared.
  - Reset mid-read discards all buffered and in-flight data.
- Full flags:
  - wr_doneN sets fullN; release of bank N clears fullN.
  - Set and release in the same cycle: fullN stays 1, no ovf.
  - Set while fullN = 1 with no release: ovf <= 1 (sticky until reset); fullN stays 1.
- Output buffer: 2-entry skid FIFO. dout/dout_vld are driven from the head entry; a pop occurs on dout_vld & dout_rdy.
- Read data and mux:
  - Bank RAM read latency is 1 cycle.
  - A registered flag records which bank the in-flight read targeted. The next cycle, din1 or din2 is selected by that flag and pushed into the FIFO.
  - The unselected bank's rd_en is always 0. rd_en1 and rd_en2 are never both 1.
- Read issue: a read is issued in a cycle only when (fifo_count + inflight − pop_this_cycle) < 2. The FIFO therefore never overflows, and dout_rdy may be held low indefinitely.
- FSM:
  - IDLE: when the selected bank's full flag (full1 if sl_dout = 1, else full2) is 1 → READ, with rd_addr = 0. No reads are issued in IDLE.
  - READ: rd_enN = 1 whenever credit allows; rd_addr increments after each issued read.
    - When the read at address DEPTH−1 is issued → DRAIN.
    - rd_addr wraps to 0 at that point.
  - DRAIN: the cycle after the last read's data is captured into the FIFO:
    - release the bank (clear fullN);
    - toggle sl_dout;
    - → IDLE.
    - The release happens regardless of FIFO occupancy.
- Latency:
  - First read is issued 1 cycle after IDLE sees the full flag.
  - dout_vld rises 2 cycles after that read.
  - Sustained throughput with dout_rdy = 1 is 1 word/cycle within a bank.
  - Each bank switch costs at least 2 idle cycles (DRAIN + IDLE).
- A bank filled out of turn (e.g. bunit2 full while sl_dout = 1 and bunit1 empty) waits; strict alternation is preserved.
- dout holds its value while dout_vld & !dout_rdy.

Decomposition:
- Shared package pingpong_pkg holds:
  - bank-select encoding constants BANK1 = 1'b1, BANK2 = 1'b0, shared with the write-side select;
  - the FSM state encoding IDLE/READ/DRAIN.
- One sub-module: pp_skid_fifo (2-entry, DATA_WIDTH wide, push/pop/count). The FSM, counters and mux stay in the top module.

Test Plan:
- Basic read: DEPTH = 4, din1 = 0x10+addr, pulse wr_done1, dout_rdy = 1 → dout 0x10,0x11,0x12,0x13 on consecutive cycles; full1 falls 1 cycle after the last capture; sl_dout → 0.
- Alternation: pulse wr_done1 then wr_done2 (din2 = 0x20+addr) → 8 words in order 0x10..0x13, 0x20..0x23; then bunit1 is read again only after a new wr_done1.
- Backpressure: dout_rdy = 0 for 10 cycles mid-bank → at most 2 words buffered, no read issued beyond credit, no loss or duplication; the stream resumes in order.
- Overrun: wr_done1 twice while full1 = 1 and still reading → ovf = 1 and stays 1; read sequence unaffected.
- Out-of-turn: wr_done2 only → no rd_en2 and dout_vld = 0 until wr_done1; then bunit1 is read, then bunit2.
- Reset mid-READ at address 2 → all outputs at reset values within the same cycle; after release, a new wr_done1 restarts from address 0.
